// File: rtl/pq_expiry_dispatch_if.sv
// Handshake bundle between the dispatcher, the priority-queue head and the
// expiry-event consumer. The slave view belongs to the dispatcher; the master
// view belongs to whatever drives the queue head and consumes the events.
interface pq_expiry_dispatch_if #(
  parameter int TIME_WIDTH    = 27,
  parameter int PAYLOAD_WIDTH = 8
);
  // Queue head side
  logic                     head_valid_i;
  logic [TIME_WIDTH-1:0]    head_data_i;
  logic [TIME_WIDTH-1:0]    head_id_i;
  logic [PAYLOAD_WIDTH-1:0] head_payload_i;
  logic                     pop_o;

  // Expiry event side
  logic                     evt_valid_o;
  logic                     evt_ready_i;
  logic [TIME_WIDTH-1:0]    evt_id_o;
  logic [PAYLOAD_WIDTH-1:0] evt_payload_o;
  logic [TIME_WIDTH-1:0]    evt_late_o;

  modport slave (
    input  head_valid_i, head_data_i, head_id_i, head_payload_i, evt_ready_i,
    output pop_o, evt_valid_o, evt_id_o, evt_payload_o, evt_late_o
  );

  modport master (
    output head_valid_i, head_data_i, head_id_i, head_payload_i, evt_ready_i,
    input  pop_o, evt_valid_o, evt_id_o, evt_payload_o, evt_late_o
  );
endinterface

// File: rtl/pq_expiry_dispatch.sv
// pq_expiry_dispatch: keeps a free-running time base, pops the priority-queue
// head once its deadline is due (wrap-safe compare) and presents it as an
// expiry event on a valid/ready output, one event in flight at a time.
module pq_expiry_dispatch #(
  parameter int TIME_WIDTH    = 27,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  tick_i,
  input  logic                  time_load_i,
  input  logic [TIME_WIDTH-1:0] time_value_i,
  output logic [TIME_WIDTH-1:0] now_o,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  expired_cnt_o,
  pq_expiry_dispatch_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                   r_state;
  logic [TIME_WIDTH-1:0]    r_now;
  logic                     r_evt_valid;
  logic [TIME_WIDTH-1:0]    r_evt_id;
  logic [PAYLOAD_WIDTH-1:0] r_evt_payload;
  logic [TIME_WIDTH-1:0]    r_evt_late;
  logic [CNT_WIDTH-1:0]     r_cnt;

  logic [TIME_WIDTH-1:0]    w_diff;
  logic                     w_due;
  logic                     w_pop;

  // Saturating increment: the pop counter sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Modular distance now - deadline; its MSB clear means the deadline is not
  // in the future, which stays correct across time-base wrap-around.
  assign w_diff = r_now - bus.head_data_i;
  assign w_due  = bus.head_valid_i & ~w_diff[TIME_WIDTH-1];

  // Pop only from IDLE, so a fresh head is always sampled between pops.
  // Gated by rst_ni so the strobe drops as soon as reset asserts.
  assign w_pop  = rst_ni & (r_state == S_IDLE) & enable_i & w_due & ~flush_i;

  assign now_o             = r_now;
  assign expired_cnt_o     = r_cnt;
  assign bus.pop_o         = w_pop;
  assign bus.evt_valid_o   = r_evt_valid;
  assign bus.evt_id_o      = r_evt_id;
  assign bus.evt_payload_o = r_evt_payload;
  assign bus.evt_late_o    = r_evt_late;

  // Time base: load has priority over tick; tick wraps modulo 2^TIME_WIDTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_now <= '0;
    end else if (time_load_i) begin
      r_now <= time_value_i;
    end else if (tick_i) begin
      r_now <= r_now + {{(TIME_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Dispatch FSM: capture the head on pop, hold it until handshake or flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_evt_valid   <= 1'b0;
      r_evt_id      <= '0;
      r_evt_payload <= '0;
      r_evt_late    <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state       <= S_HOLD;
            r_evt_valid   <= 1'b1;
            r_evt_id      <= bus.head_id_i;
            r_evt_payload <= bus.head_payload_i;
            r_evt_late    <= w_diff;
            r_cnt         <= sat_inc(r_cnt);
          end
        end
        S_HOLD: begin
          // Flush and handshake both retire the event; enable has no say here.
          if (flush_i || bus.evt_ready_i) begin
            r_state     <= S_IDLE;
            r_evt_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pq_expiry_dispatch.md
# pq_expiry_dispatch

Downstream consumer of the array priority queue. Keeps a free-running time base, compares it against the deadline of the queue's head cell, and when the head is due, pops it and presents it as an expiry event on a valid/ready output. It turns the sorted timer queue into an ordered stream of fired timers for the interrupt/event logic.

## Interface
- TIME_WIDTH, 27: width of deadline (`data`), `id` and time base.
- PAYLOAD_WIDTH, 8: cell payload width.
- CNT_WIDTH, 16: width of the saturating expiry counter.

Ports:
- clk_i  in  1  single clock, all logic rising-edge.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  dispatch enable; time base runs regardless.
- tick_i  in  1  advance time base by one.
- time_load_i  in  1  load time base from time_value_i.
- time_value_i  in  TIME_WIDTH  load value.
- now_o  out  TIME_WIDTH  current time base.
- head_valid_i  in  1  queue non-empty; head fields valid.
- head_data_i  in  TIME_WIDTH  head deadline.
- head_id_i  in  TIME_WIDTH  head id.
- head_payload_i  in  PAYLOAD_WIDTH  head payload.
- pop_o  out  1  one-cycle pop strobe to the queue.
- evt_valid_o  out  1  expiry event valid.
- evt_ready_i  in  1  consumer ready.
- evt_id_o  out  TIME_WIDTH  expired cell id.
- evt_payload_o  out  PAYLOAD_WIDTH  expired cell payload.
- evt_late_o  out  TIME_WIDTH  now minus deadline at pop.
- flush_i  in  1  discard held event, return to IDLE.
- expired_cnt_o  out  CNT_WIDTH  saturating count of pops.

## Operation
- Time base now_q: time_load_i has priority (now_q <= time_value_i); else tick_i increments modulo 2^TIME_WIDTH (all-ones wraps to 0).
- Due check, wrap-safe: diff = (now_q - head_data_i) mod 2^TIME_WIDTH; due = head_valid_i & ~diff[MSB]. Deadlines up to 2^(TIME_WIDTH-1)-1 ahead or behind are ordered correctly. Uses registered now_q, pre-load/pre-tick.
- FSM, two states:
  - IDLE: evt_valid_o=0. If enable_i & due & ~flush_i: pop_o=1 (combinational, this cycle only), capture id, payload, late=diff into output registers, increment expired_cnt (saturate at all-ones), go HOLD.
  - HOLD: evt_valid_o=1, outputs stable. On evt_valid_o & evt_ready_i -> IDLE. flush_i -> IDLE, event discarded (counter not decremented). flush_i has priority over handshake.
- pop_o never asserted in HOLD; at least one cycle separates pops, so the queue's updated head is always sampled, never a stale one.
- enable_i deasserted in HOLD does not withdraw a held event.
- head_valid_i low: no pop regardless of time.

## Timing
- Reset values: now_q=0, state IDLE, pop_o=0, evt_valid_o=0, evt_id_o=0, evt_payload_o=0, evt_late_o=0, expired_cnt_o=0. Reset asserted mid-HOLD drops the event immediately.
- Latency: head becomes due in cycle N (registered now_q) -> pop_o high in N -> evt_valid_o high in N+1.
- Max throughput: one event per 2 cycles (pop in N, handshake in N+1, next pop in N+2).
- Valid/ready: once evt_valid_o rises, it and all evt_* fields hold until handshake or flush.
- now_o is the registered now_q; a tick in cycle N is visible in N+1 and affects the due check from N+1.
- Simultaneous time_load_i and tick_i: load wins, no increment.

## Test plan
- Basic expiry: load time 100, head deadline 103, tick each cycle, ready=1 -> pop_o single pulse in cycle now_q=103, evt_valid_o next cycle with late=0, expired_cnt=1.
- Late/backpressure: deadline 50, now 60, ready=0 for 5 cycles -> one pop only, evt_late_o=10 held stable 5 cycles, handshake on ready, no second pop until IDLE.
- Wrap-around: now=2^27-2, deadline 1, tick -> no pop at 2^27-2 or 2^27-1; pop when now=1; deadline 2^27-1 at now=0 -> due, late=1.
- Back-to-back: three cells deadline 10 in queue, now=20, ready=1 -> pops in cycles N, N+2, N+4; ids in order; count=3.
- Flush/enable: event in HOLD, flush_i and evt_ready_i together -> no handshake counted by consumer, evt_valid_o=0 next cycle; enable_i=0 with due head -> no pop.
- Reset mid-HOLD: assert rst_ni low asynchronously -> evt_valid_o, pop_o, counter, now_o all 0 before next edge.
